// File: rtl/drac_pkg.sv
// Shared types for the branch resolve stage and its neighbours.
// Holds the execute-to-writeback bundle, checkpoint and age types.
package drac_pkg;

  localparam int GL_IDX_W_P = 6;
  localparam int CHKP_W     = 2;

  typedef logic [CHKP_W-1:0] checkpoint_t;

  typedef enum logic [3:0] {
    INSTR_NOP,
    INSTR_ALU,
    JAL,
    JALR,
    BEQ,
    BNE,
    BLT,
    BGE,
    BLTU,
    BGEU
  } instr_type_t;

  typedef struct packed {
    logic        is_branch;
    logic [63:0] pred_addr;
  } bpred_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } exception_t;

  typedef struct packed {
    logic                  valid;
    logic [63:0]           pc;
    bpred_t                bpred;
    logic                  branch_taken;
    logic [63:0]           result_pc;
    exception_t            ex;
    checkpoint_t           chkp;
    logic                  checkpoint_done;
    logic [GL_IDX_W_P-1:0] gl_index;
    instr_type_t           instr_type;
  } exe_wb_scalar_instr_t;

  typedef struct packed {
    logic                  wrap;
    logic [GL_IDX_W_P-1:0] idx;
  } gl_age_t;

  typedef enum logic [1:0] {
    BRS_IDLE,
    BRS_REDIRECT,
    BRS_RECOVER
  } brs_state_t;

  function automatic logic is_ctrl_flow(input instr_type_t t);
    return (t == JAL)  || (t == JALR) ||
           (t == BEQ)  || (t == BNE)  ||
           (t == BLT)  || (t == BGE)  ||
           (t == BLTU) || (t == BGEU);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_age_cmp.sv
// Graduation-list age comparator with one wrap bit.
// older_o is set when entry A was allocated before entry B.
module age_cmp #(
  parameter int W = 6
) (
  input  logic [W:0] a_i,
  input  logic [W:0] b_i,
  output logic       older_o
);

  logic same_wrap;

  assign same_wrap = (a_i[W] == b_i[W]);

  // Across a wrap the index order flips.
  assign older_o = same_wrap ?
                   (a_i[W-1:0] < b_i[W-1:0]) :
                   (a_i[W-1:0] > b_i[W-1:0]);

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks resolved branches against their prediction, holds the
// oldest mispredict redirect and pulses predictor updates.
module branch_resolve_unit
  import drac_pkg::*;
#(
  parameter int GL_IDX_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  exe_wb_scalar_instr_t instr_i,
  input  logic                 instr_wrap_i,
  input  logic                 flush_i,
  input  logic                 recover_done_i,
  output logic                 redirect_valid_o,
  input  logic                 redirect_ready_i,
  output logic [63:0]          redirect_pc_o,
  output checkpoint_t          redirect_chkp_o,
  output logic [GL_IDX_W:0]    redirect_gl_o,
  output logic                 upd_valid_o,
  output logic [63:0]          upd_pc_o,
  output logic                 upd_taken_o,
  output logic [63:0]          upd_target_o,
  output logic [CNT_W-1:0]     mispred_cnt_o
);

  brs_state_t        state_q;
  logic              rdr_valid_q;
  logic [63:0]       rdr_pc_q;
  checkpoint_t       rdr_chkp_q;
  logic [GL_IDX_W:0] rdr_gl_q;
  logic              upd_valid_q;
  logic [63:0]       upd_pc_q;
  logic              upd_taken_q;
  logic [63:0]       upd_target_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              resolvable;
  logic              mispred;
  logic [63:0]       corr_pc;
  logic [GL_IDX_W:0] gl_in;
  logic              older;
  logic              unused_cause;

  assign unused_cause = ^instr_i.ex.cause;

  assign resolvable = instr_i.valid &
                      ~instr_i.ex.valid &
                      is_ctrl_flow(instr_i.instr_type);

  assign mispred = resolvable &
    ((instr_i.branch_taken != instr_i.bpred.is_branch) |
     (instr_i.branch_taken &
      (instr_i.result_pc != instr_i.bpred.pred_addr)));

  assign corr_pc = instr_i.branch_taken ?
                   instr_i.result_pc :
                   instr_i.pc + 64'd4;

  assign gl_in = {instr_wrap_i, GL_IDX_W'(instr_i.gl_index)};

  // Saturating increment of the mispredict counter.
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  age_cmp #(
    .W(GL_IDX_W)
  ) u_age (
    .a_i    (gl_in),
    .b_i    (rdr_gl_q),
    .older_o(older)
  );

  // Redirect FSM with registered redirect, update and counter outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= BRS_IDLE;
      rdr_valid_q  <= 1'b0;
      rdr_pc_q     <= '0;
      rdr_chkp_q   <= '0;
      rdr_gl_q     <= '0;
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
      cnt_q        <= '0;
    end else begin
      upd_valid_q <= 1'b0;
      if (flush_i) begin
        state_q     <= BRS_IDLE;
        rdr_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          BRS_IDLE: begin
            if (resolvable) begin
              upd_valid_q  <= 1'b1;
              upd_pc_q     <= instr_i.pc;
              upd_taken_q  <= instr_i.branch_taken;
              upd_target_q <= instr_i.result_pc;
            end
            if (mispred) begin
              cnt_q       <= cnt_d;
              rdr_valid_q <= 1'b1;
              rdr_pc_q    <= corr_pc;
              rdr_chkp_q  <= instr_i.chkp;
              rdr_gl_q    <= gl_in;
              state_q     <= BRS_REDIRECT;
            end
          end
          BRS_REDIRECT: begin
            if (redirect_ready_i) begin
              rdr_valid_q <= 1'b0;
              state_q     <= BRS_RECOVER;
            end else begin
              if (resolvable) begin
                upd_valid_q  <= 1'b1;
                upd_pc_q     <= instr_i.pc;
                upd_taken_q  <= instr_i.branch_taken;
                upd_target_q <= instr_i.result_pc;
              end
              if (mispred) begin
                cnt_q <= cnt_d;
                if (older) begin
                  rdr_pc_q   <= corr_pc;
                  rdr_chkp_q <= instr_i.chkp;
                  rdr_gl_q   <= gl_in;
                end
              end
            end
          end
          BRS_RECOVER: begin
            if (recover_done_i) begin
              state_q <= BRS_IDLE;
            end
          end
          default: begin
            state_q <= BRS_IDLE;
          end
        endcase
      end
    end
  end

  // A mispredict without a taken checkpoint cannot be recovered cleanly.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && mispred &&
        (state_q == BRS_IDLE ||
         (state_q == BRS_REDIRECT && !redirect_ready_i))) begin
      assert (instr_i.checkpoint_done);
    end
  end

  assign redirect_valid_o = rdr_valid_q;
  assign redirect_pc_o    = rdr_pc_q;
  assign redirect_chkp_o  = rdr_chkp_q;
  assign redirect_gl_o    = rdr_gl_q;
  assign upd_valid_o      = upd_valid_q;
  assign upd_pc_o         = upd_pc_q;
  assign upd_taken_o      = upd_taken_q;
  assign upd_target_o     = upd_target_q;
  assign mispred_cnt_o    = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus
// hand sequences for handshake, replacement, recovery and reset.
module tb_branch_resolve_unit;
  import drac_pkg::*;

  localparam int GLW = 6;
  localparam int CW  = 32;

  logic                 clk;
  logic                 rst;
  exe_wb_scalar_instr_t instr;
  logic                 wrap;
  logic                 flush;
  logic                 rdone;
  logic                 rvalid;
  logic                 rready;
  logic [63:0]          rpc;
  checkpoint_t          rchkp;
  logic [GLW:0]         rgl;
  logic                 uvalid;
  logic [63:0]          upc;
  logic                 utaken;
  logic [63:0]          utarget;
  logic [CW-1:0]        cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  branch_resolve_unit #(
    .GL_IDX_W(GLW),
    .CNT_W   (CW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_i         (instr),
    .instr_wrap_i    (wrap),
    .flush_i         (flush),
    .recover_done_i  (rdone),
    .redirect_valid_o(rvalid),
    .redirect_ready_i(rready),
    .redirect_pc_o   (rpc),
    .redirect_chkp_o (rchkp),
    .redirect_gl_o   (rgl),
    .upd_valid_o     (uvalid),
    .upd_pc_o        (upc),
    .upd_taken_o     (utaken),
    .upd_target_o    (utarget),
    .mispred_cnt_o   (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    instr_type_t t;
    logic        vld;
    logic        exv;
    logic [63:0] pc;
    logic        isb;
    logic [63:0] pa;
    logic        tk;
    logic [63:0] res;
    logic        e_upd;
    logic        e_mis;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_type_t t, input logic [63:0] pc,
                       input logic isb, input logic [63:0] pa,
                       input logic tk, input logic [63:0] res,
                       input logic w, input logic [5:0] gl);
    instr = '0;
    instr.valid           = 1'b1;
    instr.instr_type      = t;
    instr.pc              = pc;
    instr.bpred.is_branch = isb;
    instr.bpred.pred_addr = pa;
    instr.branch_taken    = tk;
    instr.result_pc       = res;
    instr.gl_index        = gl;
    instr.chkp            = gl[1:0];
    instr.checkpoint_done = 1'b1;
    wrap = w;
  endtask

  task automatic idle_in();
    instr = '0;
    wrap  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"beq_tk", BEQ, 1, 0, 64'h1000, 0, 64'h0, 1,
               64'h1040, 1, 1, 64'h1040};
    tbl[1] = '{"bne_ok", BNE, 1, 0, 64'h1100, 0, 64'h0, 0,
               64'h1104, 1, 0, 64'h0};
    tbl[2] = '{"bge_nt", BGE, 1, 0, 64'h1200, 1, 64'h1300, 0,
               64'h1204, 1, 1, 64'h1204};
    tbl[3] = '{"jal_ok", JAL, 1, 0, 64'h1400, 1, 64'h1500, 1,
               64'h1500, 1, 0, 64'h0};
    tbl[4] = '{"bltu_wrap", BLTU, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1,
               64'h10, 0, 64'h0, 1, 1, 64'h0};
    tbl[5] = '{"alu", INSTR_ALU, 1, 0, 64'h1600, 0, 64'h0, 1,
               64'h1700, 0, 0, 64'h0};
    tbl[6] = '{"beq_exc", BEQ, 1, 1, 64'h1800, 0, 64'h0, 1,
               64'h1900, 0, 0, 64'h0};
    tbl[7] = '{"jalr_tgt", JALR, 1, 0, 64'h1A00, 1, 64'h2000, 1,
               64'h2004, 1, 1, 64'h2004};
    tbl[8] = '{"beq_nv", BEQ, 0, 0, 64'h1C00, 0, 64'h0, 1,
               64'h1D00, 0, 0, 64'h0};

    rst = 1'b1;
    flush = 1'b0;
    rdone = 1'b0;
    rready = 1'b0;
    idle_in();
    step();
    step();
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_uvalid", 64'(uvalid), 64'd0);
    chk("rst_rpc", rpc, 64'd0);
    chk("rst_rgl", 64'(rgl), 64'd0);
    chk("rst_rchkp", 64'(rchkp), 64'd0);
    chk("rst_upc", upc, 64'd0);
    chk("rst_utgt", utarget, 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].t, tbl[i].pc, tbl[i].isb, tbl[i].pa,
            tbl[i].tk, tbl[i].res, 1'b0, 6'd1);
      instr.valid    = tbl[i].vld;
      instr.ex.valid = tbl[i].exv;
      step();
      idle_in();
      if (tbl[i].e_mis) exp_cnt++;
      chk({tbl[i].name, "_uv"}, 64'(uvalid), 64'(tbl[i].e_upd));
      if (tbl[i].e_upd) begin
        chk({tbl[i].name, "_upc"}, upc, tbl[i].pc);
        chk({tbl[i].name, "_utk"}, 64'(utaken), 64'(tbl[i].tk));
        chk({tbl[i].name, "_utg"}, utarget, tbl[i].res);
      end
      chk({tbl[i].name, "_rv"}, 64'(rvalid), 64'(tbl[i].e_mis));
      if (tbl[i].e_mis) chk({tbl[i].name, "_rpc"}, rpc, tbl[i].e_pc);
      chk({tbl[i].name, "_cnt"}, 64'(cnt), 64'(exp_cnt));
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk({tbl[i].name, "_flush"}, 64'(rvalid), 64'd0);
    end

    drive(JALR, 64'h3000, 1, 64'h2000, 1, 64'h2008, 1'b0, 6'd7);
    step();
    idle_in();
    exp_cnt++;
    chk("hs_rv", 64'(rvalid), 64'd1);
    chk("hs_rpc", rpc, 64'h2008);
    chk("hs_cnt", 64'(cnt), 64'(exp_cnt));
    for (int k = 0; k < 2; k++) begin
      step();
      chk("hs_hold_rv", 64'(rvalid), 64'd1);
      chk("hs_hold_rpc", rpc, 64'h2008);
      chk("hs_hold_gl", 64'(rgl), 64'h07);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("hs_drop", 64'(rvalid), 64'd0);

    drive(BLT, 64'h4000, 0, 64'h0, 1, 64'h4100, 1'b0, 6'd9);
    step();
    idle_in();
    chk("rec_uv", 64'(uvalid), 64'd0);
    chk("rec_rv", 64'(rvalid), 64'd0);
    chk("rec_cnt", 64'(cnt), 64'(exp_cnt));
    rdone = 1'b1;
    step();
    rdone = 1'b0;
    drive(BLT, 64'h5000, 0, 64'h0, 1, 64'h5080, 1'b0, 6'd10);
    step();
    idle_in();
    exp_cnt++;
    chk("rec2_rv", 64'(rvalid), 64'd1);
    chk("rec2_rpc", rpc, 64'h5080);
    chk("rec2_uv", 64'(uvalid), 64'd1);
    chk("rec2_cnt", 64'(cnt), 64'(exp_cnt));
    rready = 1'b1;
    step();
    rready = 1'b0;
    rdone = 1'b1;
    step();
    rdone = 1'b0;

    drive(BEQ, 64'h6000, 0, 64'h0, 1, 64'h6040, 1'b0, 6'd5);
    step();
    exp_cnt++;
    chk("age_rpc0", rpc, 64'h6040);
    chk("age_gl0", 64'(rgl), 64'h05);
    drive(BNE, 64'h7000, 0, 64'h0, 1, 64'h7020, 1'b0, 6'd3);
    step();
    exp_cnt++;
    chk("age_rpc1", rpc, 64'h7020);
    chk("age_gl1", 64'(rgl), 64'h03);
    chk("age_chkp1", 64'(rchkp), 64'd3);
    chk("age_uv1", 64'(uvalid), 64'd1);
    chk("age_cnt1", 64'(cnt), 64'(exp_cnt));
    drive(BGEU, 64'h8000, 0, 64'h0, 1, 64'h8800, 1'b1, 6'd2);
    step();
    exp_cnt++;
    chk("age_rpc2", rpc, 64'h7020);
    chk("age_gl2", 64'(rgl), 64'h03);
    chk("age_uv2", 64'(uvalid), 64'd1);
    chk("age_upc2", upc, 64'h8000);
    chk("age_cnt2", 64'(cnt), 64'(exp_cnt));
    drive(BLTU, 64'h9000, 0, 64'h0, 1, 64'h9900, 1'b0, 6'd1);
    rready = 1'b1;
    step();
    rready = 1'b0;
    idle_in();
    chk("acc_rv", 64'(rvalid), 64'd0);
    chk("acc_uv", 64'(uvalid), 64'd0);
    chk("acc_cnt", 64'(cnt), 64'(exp_cnt));
    rdone = 1'b1;
    step();
    rdone = 1'b0;

    drive(BEQ, 64'hA000, 0, 64'h0, 1, 64'hA040, 1'b0, 6'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    chk("fl_rv", 64'(rvalid), 64'd0);
    chk("fl_uv", 64'(uvalid), 64'd0);
    chk("fl_cnt", 64'(cnt), 64'(exp_cnt));
    drive(BEQ, 64'hB000, 0, 64'h0, 1, 64'hB040, 1'b0, 6'd4);
    step();
    idle_in();
    exp_cnt++;
    chk("pre_rst_rv", 64'(rvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rv", 64'(rvalid), 64'd0);
    chk("arst_rpc", rpc, 64'd0);
    chk("arst_cnt", 64'(cnt), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_rv", 64'(rvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered stage directly downstream of the execute-stage branch unit. It takes each resolved branch/jump result and checks it against the front-end prediction carried with the instruction. On a mispredict it raises a held redirect request toward fetch and rename-checkpoint recovery, keeping only the oldest pending mispredict. It also emits a one-cycle predictor-update pulse for every resolved control-flow instruction.

## Interface
Parameters:
- GL_IDX_W, default 6: graduation-list index width; the age comparison uses one extra wrap bit.
- CNT_W, default 32: width of the mispredict statistics counter.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_i  in  exe_wb_scalar_instr_t  branch unit output. Fields used: valid, pc, bpred, branch_taken, result_pc, ex.valid, chkp, checkpoint_done, gl_index, instr_type.
- instr_wrap_i  in  1  wrap bit of instr_i.gl_index.
- flush_i  in  1  commit-side pipeline flush.
- recover_done_i  in  1  front end and rename report that recovery has completed.
- redirect_valid_o  out  1  redirect request.
- redirect_ready_i  in  1  redirect accepted.
- redirect_pc_o  out  64  correct next PC.
- redirect_chkp_o  out  checkpoint_t  checkpoint to restore.
- redirect_gl_o  out  GL_IDX_W+1  wrap bit plus gl_index of the mispredicting instruction.
- upd_valid_o  out  1  predictor update pulse.
- upd_pc_o  out  64  PC of the resolved instruction.
- upd_taken_o  out  1  actual taken outcome.
- upd_target_o  out  64  actual target.
- mispred_cnt_o  out  CNT_W  number of mispredicts detected.

## Operation
- A control-flow result is **resolvable** when instr_i.valid=1, instr_i.ex.valid=0 and instr_type is JAL, JALR, BEQ, BNE, BLT, BGE, BLTU or BGEU. Results with an exception are ignored; commit handles them.
- A resolvable result is a **mispredict** when either:
  - branch_taken differs from bpred.is_branch, or
  - branch_taken=1 and result_pc differs from bpred.pred_addr.
- Correct PC for a mispredict: result_pc if branch_taken, else pc+4 (64-bit wrap).
- The checkpoint to restore is instr_i.chkp, valid only when checkpoint_done=1.
  - A mispredict with checkpoint_done=0 is an internal error: assertion in simulation, redirect still issued.
- State machine IDLE / REDIRECT / RECOVER:
  - IDLE: a mispredict captures pc, chkp and gl into registers and moves to REDIRECT.
  - REDIRECT: redirect_valid_o=1. If another mispredict arrives and is older (age_cmp), the captured registers are overwritten. A younger one is dropped. When redirect_valid_o & redirect_ready_i, move to RECOVER.
  - RECOVER: all instr_i inputs are dropped as wrong-path, with no update and no count. recover_done_i returns to IDLE.
- flush_i has priority over everything, in any state: go to IDLE, drop the captured request, and ignore the same-cycle instr_i.
- Predictor update: every resolvable result accepted in IDLE or REDIRECT produces upd_valid_o one cycle later, carrying pc, branch_taken and result_pc. Dropped younger results in REDIRECT still update.
- mispred_cnt_o counts every detected mispredict in IDLE or REDIRECT, including replaced ones. It saturates at all-ones.

## Timing
- Reset values:
  - state IDLE.
  - redirect_valid_o=0, upd_valid_o=0.
  - redirect_pc_o=0, redirect_gl_o=0, redirect_chkp_o=0.
  - upd_pc_o=0, upd_taken_o=0, upd_target_o=0.
  - mispred_cnt_o=0.
- Latency: input in cycle N → redirect_valid_o and upd_valid_o in cycle N+1. All outputs are registered.
- Redirect handshake:
  - redirect payload is stable while valid=1 and not ready, except for an older-mispredict replacement.
  - valid deasserts the cycle after acceptance.
- Simultaneous accept and older mispredict in REDIRECT: the accept wins and the state goes to RECOVER. The new result is treated as wrong-path.
- recover_done_i in IDLE or REDIRECT is ignored.
- upd_valid_o is a single-cycle pulse and needs no handshake.
- Reset asserted mid-operation clears all state at once, regardless of the clock.

## Structure
- Shared package (drac_pkg): brs_state_t enum; checkpoint_t and exe_wb_scalar_instr_t (existing); a gl_age_t struct {wrap, idx}.
- Sub-module age_cmp: combinational. A is older than B when
  - A.wrap==B.wrap and A.idx<B.idx, or
  - A.wrap!=B.wrap and A.idx>B.idx.

## Test plan
1. BEQ, pc=0x1000, bpred not-taken, taken, result_pc=0x1040 → next cycle redirect_pc_o=0x1040, upd_taken_o=1, mispred_cnt_o=1.
2. JALR predicted taken to 0x2000, actual 0x2008 → redirect to 0x2008. With ready held low 3 cycles, the payload stays stable; valid drops the cycle after ready.
3. In REDIRECT for gl {0,5}, mispredict gl {0,3} arrives → payload replaced with the {0,3} instruction. Then gl {1,2} arrives (younger across wrap) → dropped, upd_valid_o still pulses.
4. Correctly predicted BNE not-taken → upd_valid_o=1, no redirect, counter unchanged.
5. In RECOVER, a mispredicting BLT arrives → no update, no count. recover_done_i → IDLE, then a BLT mispredict redirects normally.
6. flush_i together with a mispredict in IDLE → stays IDLE, no outputs. Reset pulse during REDIRECT → redirect_valid_o=0 immediately.
